// File: rtl/blit_addr_seq.sv
// Blitter A1 address sequencer: walks a 16.16 X/Y pointer over pixels-in-line / lines-in-blit.
// Optional window clipping when BLIT_ADDR_CLIP_EN is defined (adds win_w, win_h, clip_cnt).
module blit_addr_seq #(
  parameter int XW = 16,
  parameter int FW = 16,
  parameter int CW = 16
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x_init,
  input  logic [XW-1:0] y_init,
  input  logic [FW-1:0] fx_init,
  input  logic [FW-1:0] fy_init,
  input  logic [XW-1:0] inc_x,
  input  logic [XW-1:0] inc_y,
  input  logic [FW-1:0] inc_fx,
  input  logic [FW-1:0] inc_fy,
  input  logic [XW-1:0] step_x,
  input  logic [XW-1:0] step_y,
  input  logic [FW-1:0] step_fx,
  input  logic [FW-1:0] step_fy,
  input  logic [CW-1:0] inner_cnt,
  input  logic [CW-1:0] outer_cnt,
  input  logic [2:0]    modx,
`ifdef BLIT_ADDR_CLIP_EN
  input  logic [XW-1:0] win_w,
  input  logic [XW-1:0] win_h,
  output logic [CW-1:0] clip_cnt,
`endif
  output logic          addr_valid,
  input  logic          addr_ready,
  output logic [XW-1:0] addr_x,
  output logic [XW-1:0] addr_y,
  output logic          last_pixel,
  output logic          last_line,
  output logic          busy,
  output logic          done
);
  localparam int PW = XW + FW;

  typedef enum logic [1:0] {IDLE, ADDR, STEP, DONE} state_t;
  state_t state_q, state_d;

  logic [PW-1:0] px_q, py_q, inc_px_q, inc_py_q, step_px_q, step_py_q;
  logic [CW-1:0] pix_q, lines_q, inner_q;
  logic [2:0]    modx_q;
  logic          clipped, consume;

`ifdef BLIT_ADDR_CLIP_EN
  logic [XW-1:0] win_w_q, win_h_q;
  logic [XW-1:0] x_int, y_int;
  assign x_int   = px_q[PW-1:FW];
  assign y_int   = py_q[PW-1:FW];
  assign clipped = (state_q == ADDR) &&
                   ($signed(x_int) < 0 || $signed(x_int) >= $signed(win_w_q) ||
                    $signed(y_int) < 0 || $signed(y_int) >= $signed(win_h_q));
`else
  assign clipped = 1'b0;
`endif

  // A clipped pixel is retired exactly like an accepted one
  assign addr_valid = (state_q == ADDR) && !clipped;
  assign consume    = (state_q == ADDR) && (clipped || addr_ready);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign last_pixel = addr_valid && (pix_q == CW'(1));
  assign last_line  = busy && (lines_q == CW'(1)) && (state_q != DONE);
  assign addr_y     = py_q[PW-1:FW];

  // Mask is output-only; the stored pointer keeps its low bits
  always_comb begin
    addr_x = px_q[PW-1:FW];
    if (modx_q != 3'd0 && modx_q != 3'd7)
      for (int i = 0; i < 6; i++)
        if (i < int'(modx_q)) addr_x[i] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (inner_cnt == '0 || outer_cnt == '0) ? DONE : ADDR;
      ADDR: if (consume && pix_q == CW'(1)) state_d = (lines_q == CW'(1)) ? DONE : STEP;
      STEP: state_d = ADDR;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      px_q      <= '0;
      py_q      <= '0;
      inc_px_q  <= '0;
      inc_py_q  <= '0;
      step_px_q <= '0;
      step_py_q <= '0;
      pix_q     <= '0;
      lines_q   <= '0;
      inner_q   <= '0;
      modx_q    <= '0;
`ifdef BLIT_ADDR_CLIP_EN
      win_w_q   <= '0;
      win_h_q   <= '0;
      clip_cnt  <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          px_q      <= {x_init, fx_init};
          py_q      <= {y_init, fy_init};
          inc_px_q  <= {inc_x, inc_fx};
          inc_py_q  <= {inc_y, inc_fy};
          step_px_q <= {step_x, step_fx};
          step_py_q <= {step_y, step_fy};
          pix_q     <= inner_cnt;
          lines_q   <= outer_cnt;
          inner_q   <= inner_cnt;
          modx_q    <= modx;
`ifdef BLIT_ADDR_CLIP_EN
          win_w_q   <= win_w;
          win_h_q   <= win_h;
          clip_cnt  <= '0;
`endif
        end
        ADDR: begin
          // Last pixel of a line takes the step instead of the increment
          if (consume && pix_q != CW'(1)) begin
            px_q  <= px_q + inc_px_q;
            py_q  <= py_q + inc_py_q;
            pix_q <= pix_q - CW'(1);
          end
`ifdef BLIT_ADDR_CLIP_EN
          if (clipped) clip_cnt <= clip_cnt + CW'(1);
`endif
        end
        STEP: begin
          px_q    <= px_q + step_px_q;
          py_q    <= py_q + step_py_q;
          pix_q   <= inner_q;
          lines_q <= lines_q - CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_blit_addr_seq.sv
// Bench for blit_addr_seq: directed and random blits against a nested-loop address list.
module tb_blit_addr_seq;
  localparam int XW = 16, FW = 16, CW = 16;

  logic          sys_clk, reset, start;
  logic [XW-1:0] x_init, y_init, inc_x, inc_y, step_x, step_y;
  logic [FW-1:0] fx_init, fy_init, inc_fx, inc_fy, step_fx, step_fy;
  logic [CW-1:0] inner_cnt, outer_cnt;
  logic [2:0]    modx;
  logic          addr_valid, addr_ready, last_pixel, last_line, busy, done;
  logic [XW-1:0] addr_x, addr_y;

  blit_addr_seq #(.XW(XW), .FW(FW), .CW(CW)) dut (
    .sys_clk(sys_clk), .reset(reset), .start(start),
    .x_init(x_init), .y_init(y_init), .fx_init(fx_init), .fy_init(fy_init),
    .inc_x(inc_x), .inc_y(inc_y), .inc_fx(inc_fx), .inc_fy(inc_fy),
    .step_x(step_x), .step_y(step_y), .step_fx(step_fx), .step_fy(step_fy),
    .inner_cnt(inner_cnt), .outer_cnt(outer_cnt), .modx(modx),
    .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr_x(addr_x), .addr_y(addr_y), .last_pixel(last_pixel),
    .last_line(last_line), .busy(busy), .done(done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [15:0] x, y;
    logic        lp, ll;
  } exp_t;
  exp_t exq[$];

  int ncheck = 0, npass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncheck++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_ops(input logic [15:0] x, fx, y, fy, ix, ifx, iy, ify,
                         input logic [15:0] sx, sfx, sy, sfy, inr, outr,
                         input logic [2:0] mx);
    x_init = x; fx_init = fx; y_init = y; fy_init = fy;
    inc_x = ix; inc_fx = ifx; inc_y = iy; inc_fy = ify;
    step_x = sx; step_fx = sfx; step_y = sy; step_fy = sfy;
    inner_cnt = inr; outer_cnt = outr; modx = mx;
  endtask

  // Expected address list straight from the two-level loop description
  task automatic build_model();
    logic [31:0] px, py;
    logic [15:0] xi;
    exp_t e;
    exq.delete();
    px = {x_init, fx_init};
    py = {y_init, fy_init};
    for (int l = 0; l < int'(outer_cnt); l++) begin
      for (int p = 0; p < int'(inner_cnt); p++) begin
        xi = px[31:16];
        if (modx >= 3'd1 && modx <= 3'd6) xi = (xi >> modx) << modx;
        e.x = xi; e.y = py[31:16];
        e.lp = (p == int'(inner_cnt) - 1);
        e.ll = (l == int'(outer_cnt) - 1);
        exq.push_back(e);
        if (p < int'(inner_cnt) - 1) begin
          px = px + {inc_x, inc_fx};
          py = py + {inc_y, inc_fy};
        end
      end
      if (l < int'(outer_cnt) - 1) begin
        px = px + {step_x, step_fx};
        py = py + {step_y, step_fy};
      end
    end
  endtask

  // mode 0: ready always 1; 1: ready pattern 0,1,0,0,1; 2: random ready
  task automatic run(input int mode, input string name);
    logic        pat [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int          k = 0, done_cyc = 0, exp_done;
    logic        held = 1'b0, seen = 1'b0, rdy;
    logic [15:0] hx = '0, hy = '0;
    exp_t        e;
    int          nz;
    build_model();
    nz = (inner_cnt != 0 && outer_cnt != 0) ? 1 : 0;
    exp_done = nz ? int'(inner_cnt) * int'(outer_cnt) + int'(outer_cnt) : 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    // later operand changes must not disturb the running blit
    set_ops(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom_range(1, 7)), 16'($urandom_range(1, 7)), 3'($urandom));
    chk({name, " first_valid"}, 32'(addr_valid), 32'(nz));
    for (int cyc = 1; cyc <= 400; cyc++) begin
      start = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
        done_cyc = cyc;
        break;
      end
      if (addr_valid === 1'b1) begin
        if (held) begin
          chk({name, " stall_x"}, 32'(addr_x), 32'(hx));
          chk({name, " stall_y"}, 32'(addr_y), 32'(hy));
        end
        rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[k % 5] : 1'($urandom);
        k++;
        addr_ready = rdy;
        if (rdy) begin
          held = 1'b0;
          if (exq.size() == 0) chk({name, " extra_addr"}, 32'd1, 32'd0);
          else begin
            e = exq.pop_front();
            chk({name, " addr_x"}, 32'(addr_x), 32'(e.x));
            chk({name, " addr_y"}, 32'(addr_y), 32'(e.y));
            chk({name, " last_pixel"}, 32'(last_pixel), 32'(e.lp));
            chk({name, " last_line"}, 32'(last_line), 32'(e.ll));
          end
        end else begin
          held = 1'b1; hx = addr_x; hy = addr_y;
        end
      end else begin
        addr_ready = 1'($urandom);
      end
      if (cyc == 2 && busy === 1'b1) start = 1'b1;
      tick();
    end
    start = 1'b0;
    chk({name, " done_seen"}, 32'(seen), 32'd1);
    if (mode == 0 && seen) chk({name, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({name, " missing_addrs"}, 32'(exq.size()), 32'd0);
    tick();
    chk({name, " done_pulse"}, 32'(done), 32'd0);
    chk({name, " busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " addr_valid"}, 32'(addr_valid), 32'd0);
    chk({name, " addr_x"}, 32'(addr_x), 32'd0);
    chk({name, " addr_y"}, 32'(addr_y), 32'd0);
    chk({name, " last_pixel"}, 32'(last_pixel), 32'd0);
    chk({name, " last_line"}, 32'(last_line), 32'd0);
    chk({name, " busy"}, 32'(busy), 32'd0);
    chk({name, " done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; addr_ready = 1'b0;
    set_ops('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 3'd0);
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    set_ops(16'd10, 16'h0, 16'd5, 16'h0, 16'd1, 16'h0, 16'h0, 16'h0,
            16'h0, 16'h0, 16'h0, 16'h0, 16'd4, 16'd1, 3'd0);
    run(0, "basic");
    set_ops(16'd0, 16'h8000, 16'd0, 16'h0, 16'd0, 16'h8000, 16'h0, 16'h0,
            16'h0, 16'h0, 16'h0, 16'h0, 16'd4, 16'd1, 3'd0);
    run(0, "frac");
    set_ops(16'd0, 16'h0, 16'd0, 16'h0, 16'd1, 16'h0, 16'h0, 16'h0,
            16'hFFFD, 16'h0, 16'd1, 16'h0, 16'd3, 16'd2, 3'd0);
    run(0, "two_lines");
    set_ops(16'd7, 16'h0, 16'd3, 16'h0, 16'd2, 16'h0, 16'd1, 16'h0,
            16'hFFF8, 16'h0, 16'd1, 16'h0, 16'd4, 16'd2, 3'd0);
    run(1, "backpressure");
    set_ops(16'h003F, 16'h0, 16'd0, 16'h0, 16'd1, 16'h0, 16'h0, 16'h0,
            16'h0, 16'h0, 16'h0, 16'h0, 16'd2, 16'd1, 3'd3);
    run(0, "mask");
    set_ops(16'd1, 16'h0, 16'd1, 16'h0, 16'd1, 16'h0, 16'h0, 16'h0,
            16'h0, 16'h0, 16'h0, 16'h0, 16'd0, 16'd3, 3'd0);
    run(0, "inner_zero");
    set_ops(16'd1, 16'h0, 16'd1, 16'h0, 16'd1, 16'h0, 16'h0, 16'h0,
            16'h0, 16'h0, 16'h0, 16'h0, 16'd3, 16'd0, 3'd0);
    run(0, "outer_zero");

    for (int i = 0; i < 20; i++) begin
      set_ops(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom_range(0, 5)), 16'($urandom_range(0, 4)), 3'($urandom));
      run((i % 3 == 0) ? 0 : 2, $sformatf("rand%0d", i));
    end

    // reset in the middle of a blit: everything clears and no done follows
    set_ops(16'd9, 16'h0, 16'd9, 16'h0, 16'd1, 16'h0, 16'h0, 16'h0,
            16'h0, 16'h0, 16'd1, 16'h0, 16'd5, 16'd2, 3'd0);
    addr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_reset addr_valid", 32'(addr_valid), 32'd1);
    reset = 1'b1;
    tick();
    chk_all_zero("mid_reset");
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("post_reset no_done", 32'(ndone), 32'd0);

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end
endmodule
